// File: rtl/pic_pkg.sv
// Constants and helpers that the PIC blocks share.
package pic_pkg;

    localparam logic TRIG_EDGE  = 1'b0;
    localparam logic TRIG_LEVEL = 1'b1;
    localparam int   MAX_IRQ    = 32;

    // Index width for n channels. Never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_sync.sv
// A WIDTH-wide, STAGES-deep flop chain that brings asynchronous request lines into clk.
module irq_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] ir_i,
    output logic [WIDTH-1:0] sync_o
);

    logic [STAGES-1:0][WIDTH-1:0] stage_q;

    // NOTE: sequential state uses non-blocking assignments. Each stage then
    // samples its neighbour's value from before the edge, which builds a real shift chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= ir_i;
            for (int s = 1; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s-1];
            end
        end
    end

    assign sync_o = stage_q[STAGES-1];

endmodule

// File: rtl/irr_unit.sv
// Interrupt request register: synchronises the IR lines, latches edge- or level-mode requests,
// and presents the highest-priority unmasked, unblocked request to the control logic.
module irr_unit
    import pic_pkg::*;
#(
    parameter  int NUM_IRQ     = 8,
    parameter  int SYNC_STAGES = 2,
    localparam int ID_W        = idx_w(NUM_IRQ)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] ir_in,
    input  logic               ltim,
    input  logic [NUM_IRQ-1:0] imr,
    input  logic [NUM_IRQ-1:0] isr,
    input  logic               ack_valid,
    input  logic [ID_W-1:0]    ack_id,
    output logic [NUM_IRQ-1:0] irr,
    output logic               int_req,
    output logic [ID_W-1:0]    req_id
);

    logic [NUM_IRQ-1:0] sync;
    logic [NUM_IRQ-1:0] prev_q;
    logic [NUM_IRQ-1:0] rise;
    logic [NUM_IRQ-1:0] clr;
    logic [NUM_IRQ-1:0] cand;
    logic [NUM_IRQ-1:0] irr_q, irr_d;
    logic               ltim_q;
    logic               int_req_q, int_req_d;
    logic [ID_W-1:0]    req_id_q, req_id_d;
    logic               ack_in_range;
    logic               blocked;

    irq_sync #(
        .WIDTH  (NUM_IRQ),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .reset  (reset),
        .ir_i   (ir_in),
        .sync_o (sync)
    );

    // An out-of-range ack is only possible when the index field holds codes with no channel.
    if ((1 << ID_W) > NUM_IRQ) begin : g_ack_range
        assign ack_in_range = (ack_id < ID_W'(NUM_IRQ));
    end else begin : g_ack_full
        assign ack_in_range = 1'b1;
    end

    // NOTE: every signal that always_comb drives gets a default value first. Any
    // path that leaves a signal unassigned would otherwise infer a latch.
    always_comb begin
        rise = sync & ~prev_q;
        clr  = '0;
        for (int i = 0; i < NUM_IRQ; i++) begin
            clr[i] = ack_valid & ack_in_range & (ack_id == ID_W'(i));
        end

        irr_d = irr_q;
        if (ltim != ltim_q) begin
            irr_d = '0;
        end else if (ltim_q == TRIG_LEVEL) begin
            irr_d = sync & ~imr;
        end else begin
            // The set term is applied after the clear term, so a new edge wins over a same-cycle ack.
            irr_d = (irr_q & ~clr) | (rise & ~imr);
        end
    end

    // NOTE: this loop uses blocking assignments on purpose. The isr blocking flag and the found
    // flag must carry from the lower channels to the higher ones within one evaluation.
    always_comb begin
        cand      = irr_q & ~imr;
        blocked   = 1'b0;
        int_req_d = 1'b0;
        req_id_d  = req_id_q;
        for (int i = 0; i < NUM_IRQ; i++) begin
            blocked = blocked | isr[i];
            if (cand[i] && !blocked && !int_req_d) begin
                int_req_d = 1'b1;
                req_id_d  = ID_W'(i);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q    <= '0;
            ltim_q    <= TRIG_EDGE;
            irr_q     <= '0;
            int_req_q <= 1'b0;
            req_id_q  <= '0;
        end else begin
            prev_q    <= sync;
            ltim_q    <= ltim;
            irr_q     <= irr_d;
            int_req_q <= int_req_d;
            req_id_q  <= req_id_d;
        end
    end

    assign irr     = irr_q;
    assign int_req = int_req_q;
    assign req_id  = req_id_q;

endmodule

// File: tb/tb_irr_unit.sv
// Directed scoreboard bench for irr_unit with three builds: the 8-channel default,
// a 5-channel build with unused ack codes, and a 16-channel build with 3 synchroniser stages.
module tb_irr_unit;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic clk = 1'b0;
    logic rst;

    logic [7:0]  ir8, imr8, isr8, irr8;
    logic        ltim8, ackv8, intr8;
    logic [2:0]  ackid8, rid8;

    logic [4:0]  ir5, imr5, isr5, irr5;
    logic        ltim5, ackv5, intr5;
    logic [2:0]  ackid5, rid5;

    logic [15:0] ir16, imr16, isr16, irr16;
    logic        ltim16, ackv16, intr16;
    logic [3:0]  ackid16, rid16;

    always #5 clk = ~clk;

    irr_unit #(.NUM_IRQ(8), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .reset(rst), .ir_in(ir8), .ltim(ltim8), .imr(imr8), .isr(isr8),
        .ack_valid(ackv8), .ack_id(ackid8), .irr(irr8), .int_req(intr8), .req_id(rid8)
    );

    irr_unit #(.NUM_IRQ(5), .SYNC_STAGES(2)) dut5 (
        .clk(clk), .reset(rst), .ir_in(ir5), .ltim(ltim5), .imr(imr5), .isr(isr5),
        .ack_valid(ackv5), .ack_id(ackid5), .irr(irr5), .int_req(intr5), .req_id(rid5)
    );

    irr_unit #(.NUM_IRQ(16), .SYNC_STAGES(3)) dut16 (
        .clk(clk), .reset(rst), .ir_in(ir16), .ltim(ltim16), .imr(imr16), .isr(isr16),
        .ack_valid(ackv16), .ack_id(ackid16), .irr(irr16), .int_req(intr16), .req_id(rid16)
    );

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_cmp++;
        if (sb_q.size() == 0) begin
            n_bad++;
            $error("FAIL sb_underflow: observed %0h required a queued expectation", obs);
        end else begin
            e = sb_q.pop_front();
            assert (obs === e.val) else begin
                n_bad++;
                $error("FAIL %s: observed %0h required %0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ir8 = '0; imr8 = '0; isr8 = '0; ltim8 = 1'b0; ackv8 = 1'b0; ackid8 = '0;
        ir5 = '0; imr5 = '0; isr5 = '0; ltim5 = 1'b0; ackv5 = 1'b0; ackid5 = '0;
        ir16 = '0; imr16 = '0; isr16 = '0; ltim16 = 1'b0; ackv16 = 1'b0; ackid16 = '0;

        // Reset state
        #2;
        push("rst_irr", 'h0); push("rst_int", 'h0); push("rst_id", 'h0); push("rst_irr16", 'h0);
        check(32'(irr8)); check(32'(intr8)); check(32'(rid8)); check(32'(irr16));
        step(2);
        rst = 1'b0;

        // Edge mode: ch3 rises and is held high
        ir8 = 8'h08;
        push("e3_irr_early", 'h00); push("e3_irr", 'h08); push("e3_int_early", 'h0);
        push("e3_int", 'h1); push("e3_id", 'h3); push("e3_hold_irr", 'h08); push("e3_hold_int", 'h1);
        step(2); check(32'(irr8));
        step(1); check(32'(irr8)); check(32'(intr8));
        step(1); check(32'(intr8)); check(32'(rid8));
        step(4); check(32'(irr8)); check(32'(intr8));

        // Ack ch3 while its line is still held: no retrigger afterwards
        ackv8 = 1'b1; ackid8 = 3'd3;
        push("ack3_irr", 'h00); push("ack3_int", 'h0); push("ack3_id_hold", 'h3);
        step(1); ackv8 = 1'b0; check(32'(irr8));
        step(1); check(32'(intr8)); check(32'(rid8));
        ir8 = 8'h00;

        // Masked edge is dropped and not recovered on unmask
        imr8 = 8'h20; ir8 = 8'h20;
        step(1); ir8 = 8'h00;
        step(3); imr8 = 8'h00;
        push("mask5_irr", 'h00); push("mask5_int", 'h0);
        step(3); check(32'(irr8)); check(32'(intr8));

        // Priority and in-service blocking with irr = 8'h24
        ir8 = 8'h24;
        step(1); ir8 = 8'h00;
        push("pri_irr", 'h24); push("pri_int", 'h1); push("pri_id", 'h2);
        step(3); check(32'(irr8)); check(32'(intr8)); check(32'(rid8));
        isr8 = 8'h04;
        push("isr04_int", 'h0); push("isr04_id_hold", 'h2);
        step(1); check(32'(intr8)); check(32'(rid8));
        isr8 = 8'h40;
        push("isr40_int", 'h1); push("isr40_id", 'h2);
        step(1); check(32'(intr8)); check(32'(rid8));
        isr8 = 8'h01;
        push("isr01_int", 'h0);
        step(1); check(32'(intr8));
        isr8 = 8'h00;

        // Ack ch2 leaves ch5 as the winner
        ackv8 = 1'b1; ackid8 = 3'd2;
        push("ack2_irr", 'h20); push("ack2_int", 'h1); push("ack2_id", 'h5);
        step(1); ackv8 = 1'b0; check(32'(irr8));
        step(1); check(32'(intr8)); check(32'(rid8));

        // A new ch5 edge in the same cycle as ack of ch5: the set wins
        ir8 = 8'h20;
        step(2); ackv8 = 1'b1; ackid8 = 3'd5;
        push("coll_irr", 'h20);
        step(1); ackv8 = 1'b0; check(32'(irr8));
        ackv8 = 1'b1; ackid8 = 3'd5;
        push("ack5_irr", 'h00);
        step(1); ackv8 = 1'b0; check(32'(irr8));
        ir8 = 8'h00;

        // Level mode on ch1
        ltim8 = 1'b1;
        step(1);
        ir8 = 8'h02;
        push("lvl_irr_early", 'h00); push("lvl_irr", 'h02);
        step(2); check(32'(irr8));
        step(1); check(32'(irr8));
        ackv8 = 1'b1; ackid8 = 3'd1;
        push("lvl_ack_irr", 'h02);
        step(1); ackv8 = 1'b0; check(32'(irr8));
        step(1);
        ir8 = 8'h00;
        push("lvl_fall_early", 'h02); push("lvl_fall", 'h00);
        step(2); check(32'(irr8));
        step(1); check(32'(irr8));
        ir8 = 8'h02;
        step(3); imr8 = 8'h02;
        push("lvl_masked", 'h00);
        step(1); check(32'(irr8));
        imr8 = 8'h00;
        push("lvl_unmasked", 'h02);
        step(1); check(32'(irr8));

        // Toggle ltim: each change clears irr for one cycle
        ltim8 = 1'b0;
        push("tog_to_edge", 'h00);
        step(1); check(32'(irr8));
        ltim8 = 1'b1;
        push("tog_to_level", 'h00); push("tog_level_apply", 'h02);
        step(1); check(32'(irr8));
        step(1); check(32'(irr8));
        ltim8 = 1'b0; ir8 = 8'h00;
        step(4);

        // Async reset mid-request
        ir8 = 8'hFF;
        step(1); ir8 = 8'h00;
        push("all_irr", 'hFF); push("all_int", 'h1); push("all_id", 'h0);
        step(3); check(32'(irr8)); check(32'(intr8)); check(32'(rid8));
        imr8 = 8'h01;
        push("all_id_m0", 'h1); push("all_irr_m0", 'hFF);
        step(1); check(32'(rid8)); check(32'(irr8));
        #2 rst = 1'b1;
        #1;
        push("arst_irr", 'h00); push("arst_int", 'h0); push("arst_id", 'h0);
        check(32'(irr8)); check(32'(intr8)); check(32'(rid8));
        ir8 = 8'h10; imr8 = 8'h00;
        push("arst_hold_irr", 'h00);
        step(1); check(32'(irr8));
        rst = 1'b0;
        push("rel_irr_early", 'h00); push("rel_irr", 'h10); push("rel_int", 'h1); push("rel_id", 'h4);
        step(2); check(32'(irr8));
        step(1); check(32'(irr8));
        step(1); check(32'(intr8)); check(32'(rid8));
        ir8 = 8'h00;

        // 5-channel build: ack codes 5..7 have no channel and are ignored
        ir5 = 5'h1F;
        step(1); ir5 = 5'h00;
        push("n5_irr", 'h1F); push("n5_id", 'h0);
        step(3); check(32'(irr5)); check(32'(rid5));
        ackv5 = 1'b1; ackid5 = 3'd6;
        push("n5_ack6", 'h1F);
        step(1); check(32'(irr5));
        ackid5 = 3'd7;
        push("n5_ack7", 'h1F);
        step(1); check(32'(irr5));
        ackid5 = 3'd5;
        push("n5_ack5", 'h1F);
        step(1); check(32'(irr5));
        ackid5 = 3'd4;
        push("n5_ack4", 'h0F);
        step(1); ackv5 = 1'b0; check(32'(irr5));

        // 16-channel, 3-stage build: ch15 latency
        ir16 = 16'h8000;
        push("n16_irr_early", 'h0000); push("n16_int_early", 'h0);
        push("n16_irr", 'h8000); push("n16_int", 'h1); push("n16_id", 'hF);
        step(3); check(32'(irr16)); check(32'(intr16));
        step(1); check(32'(irr16));
        step(1); check(32'(intr16)); check(32'(rid16));
        ir16 = 16'h0000;

        n_cmp++;
        assert (sb_q.size() == 0) else begin
            n_bad++;
            $error("FAIL sb_leftover: observed %0d entries required 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/irr_unit.md
Name: irr_unit

Overview:
Parametrised interrupt request register for the PIC, supporting NUM_IRQ channels.
- Synchronises the asynchronous IR lines to clk and latches requests in edge or level trigger mode.
- Applies the IMR and the in-service blocking rule, then presents the highest-priority pending request to the control logic.
- A pending bit is cleared when the control logic acknowledges that channel.

Parameters:
NUM_IRQ, 8, number of interrupt request channels (legal range 2..32)
SYNC_STAGES, 2, flip-flop stages in each IR input synchroniser (>=1)
ID_W, $clog2(NUM_IRQ), width of channel index fields (derived, not overridden)

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
ir_in  input  NUM_IRQ  raw asynchronous interrupt request lines
ltim  input  1  trigger mode: 0 = edge, 1 = level (ICW1 LTIM)
imr  input  NUM_IRQ  interrupt mask; 1 = channel masked
isr  input  NUM_IRQ  in-service bits from the ISR block
ack_valid  input  1  acknowledge strobe, one cycle per acknowledge
ack_id  input  ID_W  channel being acknowledged
irr  output  NUM_IRQ  pending request register (OCW3 read-back)
int_req  output  1  registered: an unmasked, unblocked request is pending
req_id  output  ID_W  registered index of the highest-priority request

Behaviour:
- Reset (asynchronous, active-high) forces all synchroniser flops, edge-history flops, irr, int_req and req_id to 0 immediately. They stay 0 while reset is asserted.
- Synchroniser: each ir_in bit passes through SYNC_STAGES flops; sync[i] is the last stage.
- Edge mode (ltim=0):
  - rise[i] = sync[i] & ~prev[i], where prev[i] is sync[i] delayed one cycle.
  - The set condition is rise[i] & ~imr[i]. A rising edge that arrives while the channel is masked is discarded and is not recovered when the mask is removed.
  - irr[i] stays set until cleared by an acknowledge. A held-high line does not re-set irr[i].
- Level mode (ltim=1):
  - irr[i] <= sync[i] & ~imr[i] every cycle.
  - ack has no effect; the bit drops only when the line falls or the channel is masked.
- Acknowledge (edge mode): ack_valid with ack_id < NUM_IRQ clears irr[ack_id] at the next edge.
  - ack_id >= NUM_IRQ is ignored.
  - If a set and a clear hit the same bit in the same cycle, the set wins and the bit stays 1.
- Mode change: when ltim differs from its value in the previous cycle, irr is cleared to 0 for one cycle. The new mode applies from the following cycle. prev is not cleared.
- Priority resolution (fixed priority, channel 0 highest):
  - cand = irr & ~imr.
  - Channel i is eligible if cand[i]=1 and isr has no bit set at any index <= i.
  - req_id = lowest eligible index; int_req = 1 if any channel is eligible.
  - Both are registered, one cycle after irr/imr/isr.
  - When no channel is eligible, int_req=0 and req_id holds its previous value.
- Latency (edge mode, SYNC_STAGES=2): ir_in first sampled high at edge E gives irr[i]=1 after edge E+2 and int_req=1 after edge E+3. In general, irr is set after edge E+SYNC_STAGES and int_req after edge E+SYNC_STAGES+1.
- Reset mid-operation: pending edges are lost. A line held high through reset release produces an edge-mode request, since prev resets to 0.

Decomposition:
- Shared package pic_pkg:
  - trigger-mode constants TRIG_EDGE=0 and TRIG_LEVEL=1
  - function idx_w(n) giving the index width
  - constant MAX_IRQ=32
- Sub-module irq_sync: a NUM_IRQ-wide, SYNC_STAGES-deep synchroniser vector, instantiated once.
- Edge detection, the irr update and the priority encoder stay in irr_unit.

Test Plan:
- Edge, unmasked: ir_in[3] rises 0->1 and is held high, imr=0, isr=0 -> irr=8'h08 after 2 edges, int_req=1 and req_id=3 after 3 edges. irr stays 8'h08 while the line is held high, with no retrigger.
- Masked edge dropped: imr[5]=1, pulse ir_in[5], then imr[5]=0 -> irr[5] stays 0 and int_req stays 0.
- Priority and in-service blocking: irr=8'h24 (ch2, ch5), isr=0 -> req_id=2. With isr=8'h04 -> int_req=0. With isr=8'h40 -> req_id=2.
- Acknowledge and collision: ack_valid=1, ack_id=2 with irr=8'h24 -> irr=8'h20. Repeat with a new ch5 edge arriving in the same cycle as ack_id=5 -> irr[5] stays 1. ack_id=NUM_IRQ (when representable) -> no change.
- Level mode: ltim=1, ir_in[1] held high 4 cycles then low -> irr[1] tracks sync[1]. ack on ch1 has no effect. Toggling ltim clears irr for one cycle.
- Async reset: assert reset mid-request with irr=8'hFF and int_req=1 -> all outputs 0 immediately, with no clock edge needed. Run with NUM_IRQ=16 and SYNC_STAGES=3: ch15 edge -> int_req=1 and req_id=15 after 4 edges.
